// File: rtl/fetch_queue_if.sv
// fetch_queue_if
//   Bundles the fetch front end's external handshakes: the instruction RAM
//   read port, the decoder-facing valid/ready head, the redirect request and
//   the link-register write produced by branch-with-link.
//
//   master : the fetch queue itself (drives RAM address/request, head, link)
//   slave  : the surroundings (RAM data, decoder ready, redirect request)
//
//   Signals
//     imem_addr / imem_re / imem_q     instruction RAM read port
//     out_valid / out_instr / out_pc   queue head presented to the decoder
//     out_ready                        decoder accepts the head
//     br_valid / br_target / br_link   redirect request and link qualifier
//     link_we / link_addr              link register write
interface fetch_queue_if #(
  parameter int FULLW = 32
);
  logic [FULLW-1:0] imem_addr;
  logic             imem_re;
  logic [FULLW-1:0] imem_q;
  logic             out_valid;
  logic [FULLW-1:0] out_instr;
  logic [FULLW-1:0] out_pc;
  logic             out_ready;
  logic             br_valid;
  logic [FULLW-1:0] br_target;
  logic             br_link;
  logic             link_we;
  logic [FULLW-1:0] link_addr;

  modport master (
    output imem_addr, imem_re, out_valid, out_instr, out_pc, link_we, link_addr,
    input  imem_q, out_ready, br_valid, br_target, br_link
  );

  modport slave (
    input  imem_addr, imem_re, out_valid, out_instr, out_pc, link_we, link_addr,
    output imem_q, out_ready, br_valid, br_target, br_link
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue
//   Instruction-fetch front end. Owns the PC, issues reads to a synchronous
//   instruction RAM (one cycle read latency), buffers returned words in a
//   DEPTH-entry prefetch queue and presents the head to the decoder with a
//   valid/ready handshake. A redirect accepted together with the head flushes
//   the queue, kills the word in flight and restarts fetch at the target;
//   branch-with-link additionally produces a one-cycle link register write.
//
//   Ports
//     clk         system clock, rising edge
//     reset       synchronous, active-high
//     bus         fetch_queue_if.master (RAM port, head, redirect, link)
//     perf_stall  (FETCH_PERF_EN only) cycles with head valid but not accepted
//     perf_flush  (FETCH_PERF_EN only) taken redirects
//
//   Build option
//     FETCH_PERF_EN  adds the two saturating performance counters.
module fetch_queue #(
  parameter int               FULLW    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [FULLW-1:0] RESET_PC = '0,
  parameter logic [FULLW-1:0] PC_STEP  = FULLW'(4)
) (
  input  logic        clk,
  input  logic        reset,
  fetch_queue_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_stall,
  output logic [15:0] perf_flush
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [FULLW-1:0] pc_q;
  logic [CW-1:0]    count_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW-1:0]    wr_ptr_q;
  logic             inflight_q;
  logic [FULLW-1:0] inflight_pc_q;
  logic             link_we_q;
  logic [FULLW-1:0] link_addr_q;

  logic [FULLW-1:0] instr_mem [DEPTH];
  logic [FULLW-1:0] pc_mem    [DEPTH];

  logic             head_valid;
  logic [FULLW-1:0] head_pc;
  logic             pop;
  logic             take;
  logic             enq;
  logic             issue;
  logic [CW:0]      occupancy;

  assign head_valid = (count_q != '0);
  assign head_pc    = head_valid ? pc_mem[rd_ptr_q] : '0;
  assign pop        = head_valid & bus.out_ready;
  assign take       = pop & bus.br_valid;

  // Slots already claimed once this cycle's pop is accounted for; issuing only
  // below DEPTH guarantees the returning word always has a free entry.
  assign occupancy  = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign issue      = ~reset & ~take & (occupancy < (CW+1)'(DEPTH));

  // A word returning in the same cycle as a taken redirect is stale.
  assign enq        = inflight_q & ~take;

  assign bus.imem_addr = pc_q;
  assign bus.imem_re   = issue;
  assign bus.out_valid = head_valid;
  assign bus.out_pc    = head_pc;
  assign bus.out_instr = head_valid ? instr_mem[rd_ptr_q] : '0;
  assign bus.link_we   = link_we_q;
  assign bus.link_addr = link_addr_q;

  // Queue storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (enq) begin
      instr_mem[wr_ptr_q] <= bus.imem_q;
      pc_mem[wr_ptr_q]    <= inflight_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      link_we_q     <= 1'b0;
      link_addr_q   <= '0;
    end else begin
      link_we_q <= take & bus.br_link;
      if (take & bus.br_link) begin
        link_addr_q <= head_pc + PC_STEP;
      end
      if (take) begin
        // Flush: discard the queue and the word in flight, restart at target.
        count_q    <= '0;
        rd_ptr_q   <= wr_ptr_q;
        inflight_q <= 1'b0;
        pc_q       <= bus.br_target;
      end else begin
        if (enq) begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
        count_q    <= count_q + CW'(enq) - CW'(pop);
        inflight_q <= issue;
        if (issue) begin
          inflight_pc_q <= pc_q;
          pc_q          <= pc_q + PC_STEP;
        end
      end
    end
  end

`ifdef FETCH_PERF_EN
  // Saturating counters: stalled head cycles and taken redirects.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall <= '0;
      perf_flush <= '0;
    end else begin
      if (head_valid & ~bus.out_ready & (perf_stall != '1)) begin
        perf_stall <= perf_stall + 32'd1;
      end
      if (take & (perf_flush != '1)) begin
        perf_flush <= perf_flush + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue
//   Self-checking bench for fetch_queue: a table of directed per-cycle
//   vectors (startup, back-pressure, branch, branch-with-link, reset with a
//   partly full queue), a RESET_PC wrap-around instance, a randomized phase
//   against a queue-level reference model and, with FETCH_PERF_EN, the
//   performance counters.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] key;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  fetch_queue_if #(.FULLW(32)) fq_bus ();
  fetch_queue_if #(.FULLW(32)) fw_bus ();

`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall, w_perf_stall;
  logic [15:0] perf_flush, w_perf_flush;
`endif

  fetch_queue #(.FULLW(32), .DEPTH(4), .RESET_PC(32'h0), .PC_STEP(32'h4)) dut (
    .clk(clk), .reset(reset), .bus(fq_bus)
`ifdef FETCH_PERF_EN
    , .perf_stall(perf_stall), .perf_flush(perf_flush)
`endif
  );

  fetch_queue #(.FULLW(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8), .PC_STEP(32'h4)) dut_w (
    .clk(clk), .reset(reset), .bus(fw_bus)
`ifdef FETCH_PERF_EN
    , .perf_stall(w_perf_stall), .perf_flush(w_perf_flush)
`endif
  );

  // Synchronous instruction RAMs: word content is address ^ key.
  always @(posedge clk) begin
    if (fq_bus.imem_re) fq_bus.imem_q <= fq_bus.imem_addr ^ key;
    if (fw_bus.imem_re) fw_bus.imem_q <= fw_bus.imem_addr;
  end

  typedef struct {
    logic        rst;
    logic        ready;
    logic        brv;
    logic [31:0] brt;
    logic        brl;
    logic        chk;
    logic        ev;
    logic [31:0] epc;
    logic        ere;
    logic [31:0] eaddr;
    logic        elwe;
    logic [31:0] elad;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic ready, input logic brv,
                              input logic [31:0] brt, input logic brl, input logic chk,
                              input logic ev, input logic [31:0] epc, input logic ere,
                              input logic [31:0] eaddr, input logic elwe,
                              input logic [31:0] elad);
    vec_t v;
    v.rst = rst; v.ready = ready; v.brv = brv; v.brt = brt; v.brl = brl;
    v.chk = chk; v.ev = ev; v.epc = epc; v.ere = ere; v.eaddr = eaddr;
    v.elwe = elwe; v.elad = elad;
    return v;
  endfunction

  function automatic vec_t stim(input logic rst, input logic ready, input logic brv,
                                input logic [31:0] brt, input logic brl);
    return mk(rst, ready, brv, brt, brl, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endfunction

  // Two reset cycles; the second one checks the cleared outputs.
  task automatic addReset(input logic ready);
    vecs.push_back(stim(1'b1, ready, 1'b0, 32'h0, 1'b0));
    vecs.push_back(mk(1'b1, ready, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0));
  endtask

  // Plain streaming cycle n (n = 1 is the first cycle after reset release).
  function automatic vec_t streamRow(input int n);
    return mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, (n >= 3), 32'(4 * (n - 3)),
              1'b1, 32'(4 * (n - 1)), 1'b0, 32'h0);
  endfunction

  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    reset            = v.rst;
    fq_bus.out_ready = v.ready;
    fq_bus.br_valid  = v.brv;
    fq_bus.br_target = v.brt;
    fq_bus.br_link   = v.brl;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkRow(input vec_t v, input string tag);
    checkOutput({tag, " out_valid"}, 32'(fq_bus.out_valid), 32'(v.ev));
    if (v.ev) begin
      checkOutput({tag, " out_pc"}, fq_bus.out_pc, v.epc);
      checkOutput({tag, " out_instr"}, fq_bus.out_instr, v.epc ^ key);
    end
    checkOutput({tag, " imem_re"}, 32'(fq_bus.imem_re), 32'(v.ere));
    if (v.ere) checkOutput({tag, " imem_addr"}, fq_bus.imem_addr, v.eaddr);
    checkOutput({tag, " link_we"}, 32'(fq_bus.link_we), 32'(v.elwe));
    if (v.elwe) checkOutput({tag, " link_addr"}, fq_bus.link_addr, v.elad);
  endtask

  // Reference model state for the randomized phase.
  logic [31:0] mq[$];
  bit          m_infl;
  logic [31:0] m_infl_pc;
  logic [31:0] m_fpc;
  bit          m_link_pend;
  logic [31:0] m_link_val;

  initial begin
    reset            = 1'b1;
    key              = 32'h0;
    fq_bus.out_ready = 1'b0;
    fq_bus.br_valid  = 1'b0;
    fq_bus.br_target = 32'h0;
    fq_bus.br_link   = 1'b0;
    fw_bus.out_ready = 1'b1;
    fw_bus.br_valid  = 1'b0;
    fw_bus.br_target = 32'h0;
    fw_bus.br_link   = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset out_valid", 32'(fq_bus.out_valid), 32'h0);
    checkOutput("reset imem_re", 32'(fq_bus.imem_re), 32'h0);
    checkOutput("reset link_we", 32'(fq_bus.link_we), 32'h0);
    checkOutput("reset link_addr", fq_bus.link_addr, 32'h0);
    checkOutput("reset out_pc", fq_bus.out_pc, 32'h0);
    checkOutput("reset out_instr", fq_bus.out_instr, 32'h0);

    // Startup latency and streaming.
    addReset(1'b1);
    for (int n = 1; n <= 6; n++) vecs.push_back(streamRow(n));

    // Back-pressure: fill to DEPTH, then drain without gaps.
    addReset(1'b0);
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 32'h0, 1, 32'h0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 32'h0, 1, 32'h4, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 32'h0, 1, 32'h8, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 32'h0, 1, 32'hC, 0, 0));
    for (int n = 5; n <= 10; n++)
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 32'h0, 0, 32'h0, 0, 0));
    for (int n = 11; n <= 16; n++)
      vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1, 32'(4 * (n - 11)), 1, 32'(16 + 4 * (n - 11)), 0, 0));

    // Plain branch at 0x8 to 0x100.
    addReset(1'b1);
    for (int n = 1; n <= 4; n++) vecs.push_back(streamRow(n));
    vecs.push_back(mk(0, 1, 1, 32'h100, 0, 1, 1, 32'h8, 0, 32'h0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 32'h0, 1, 32'h100, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 32'h0, 1, 32'h104, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1, 32'h100, 1, 32'h108, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1, 32'h104, 1, 32'h10C, 0, 0));

    // Branch-with-link at 0x20 to 0x40.
    addReset(1'b1);
    for (int n = 1; n <= 10; n++) vecs.push_back(streamRow(n));
    vecs.push_back(mk(0, 1, 1, 32'h40, 1, 1, 1, 32'h20, 0, 32'h0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 32'h0, 1, 32'h40, 1, 32'h24));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 32'h0, 1, 32'h44, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1, 32'h40, 1, 32'h48, 0, 0));

    // Reset with three queued entries, then restart.
    addReset(1'b0);
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 32'h0, 1, 32'h0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 32'h0, 1, 32'h4, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 32'h0, 1, 32'h8, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 32'h0, 1, 32'hC, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 32'h0, 0, 32'h0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 32'h0, 1, 32'h0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 32'h0, 1, 32'h4, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1, 32'h0, 1, 32'h8, 0, 0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      if (vecs[i].chk) checkRow(vecs[i], $sformatf("row%0d", i));
    end

    // RESET_PC near the top of the address space wraps to zero.
    applyStimulus(stim(1, 1, 0, 0, 0));
    applyStimulus(stim(1, 1, 0, 0, 0));
    for (int n = 1; n <= 6; n++) begin
      logic [31:0] exp_pc;
      exp_pc = 32'hFFFF_FFF8 + 32'(4 * (n - 3));
      applyStimulus(stim(0, 1, 0, 0, 0));
      @(negedge clk);
      checkOutput($sformatf("wrap c%0d out_valid", n), 32'(fw_bus.out_valid), 32'(n >= 3));
      if (n >= 3) begin
        checkOutput($sformatf("wrap c%0d out_pc", n), fw_bus.out_pc, exp_pc);
        checkOutput($sformatf("wrap c%0d out_instr", n), fw_bus.out_instr, exp_pc);
      end
    end

    // Randomized traffic against a queue-level reference model.
    key = 32'h1357_0000;
    applyStimulus(stim(1, 0, 0, 0, 0));
    applyStimulus(stim(1, 0, 0, 0, 0));
    mq.delete();
    m_infl      = 0;
    m_infl_pc   = 32'h0;
    m_fpc       = 32'h0;
    m_link_pend = 0;
    m_link_val  = 32'h0;
    for (int c = 0; c < 400; c++) begin
      vec_t   v;
      bit     ev, pop, take, ere;
      logic [31:0] epc;
      v = stim(1'b0, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 2),
               {20'h0, 10'($urandom_range(0, 1023)), 2'b00}, 1'($urandom_range(0, 1)));
      applyStimulus(v);
      @(negedge clk);
      ev   = (mq.size() != 0);
      epc  = ev ? mq[0] : 32'h0;
      pop  = ev && v.ready;
      take = pop && v.brv;
      ere  = ((mq.size() + int'(m_infl) - int'(pop)) < 4) && !take;
      v.chk = 1'b1; v.ev = ev; v.epc = epc; v.ere = ere; v.eaddr = m_fpc;
      v.elwe = m_link_pend; v.elad = m_link_val;
      checkRow(v, $sformatf("rand%0d", c));
      if (take) begin
        m_link_pend = v.brl;
        if (v.brl) m_link_val = epc + 32'h4;
        mq.delete();
        m_infl = 0;
        m_fpc  = v.brt;
      end else begin
        m_link_pend = 0;
        if (pop) void'(mq.pop_front());
        if (m_infl) mq.push_back(m_infl_pc);
        m_infl = ere;
        if (ere) begin
          m_infl_pc = m_fpc;
          m_fpc     = m_fpc + 32'h4;
        end
      end
    end

`ifdef FETCH_PERF_EN
    // Five stalled head cycles and two taken redirects.
    applyStimulus(stim(1, 1, 0, 0, 0));
    applyStimulus(stim(1, 1, 0, 0, 0));
    applyStimulus(stim(0, 1, 0, 0, 0));
    applyStimulus(stim(0, 1, 0, 0, 0));
    applyStimulus(stim(0, 1, 1, 32'h100, 0));
    applyStimulus(stim(0, 1, 0, 0, 0));
    applyStimulus(stim(0, 1, 0, 0, 0));
    for (int n = 0; n < 5; n++) applyStimulus(stim(0, 0, 0, 0, 0));
    applyStimulus(stim(0, 1, 1, 32'h200, 0));
    applyStimulus(stim(0, 1, 0, 0, 0));
    @(negedge clk);
    checkOutput("perf_stall count", perf_stall, 32'd5);
    checkOutput("perf_flush count", 32'(perf_flush), 32'd2);
    applyStimulus(stim(1, 1, 0, 0, 0));
    applyStimulus(stim(1, 1, 0, 0, 0));
    @(negedge clk);
    checkOutput("perf_stall reset", perf_stall, 32'd0);
    checkOutput("perf_flush reset", 32'(perf_flush), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
